// File: rtl/mem_lsu.sv
// mem_lsu: multi-cycle load/store unit for the MIPS32 memory stage.
// Drives a req/ack data bus, stalls the pipeline while a transfer is in
// flight, reports misaligned/bus-error/timeout exceptions and keeps the
// LL/SC link bit and link word address.
module mem_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata_in,
  input  logic              flush,
  input  logic              llbit_clr,
  output logic              stall_req,
  output logic              done,
  output logic [31:0]       rdata_o,
  output logic [1:0]        exc_o,
  output logic [ADDR_W-1:0] bad_addr_o,
  output logic              llbit_o,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [31:0]       bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;
  localparam logic [3:0] OP_LL  = 4'd8;
  localparam logic [3:0] OP_SC  = 4'd9;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;
  localparam logic [1:0] EXC_BUS  = 2'd3;

  // Counter only needs to reach TIMEOUT-1.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Access size: 0 byte, 1 halfword, 2 word.
  function automatic logic [1:0] op_size(input logic [3:0] o);
    logic [1:0] s;
    case (o)
      OP_LB, OP_LBU, OP_SB: s = 2'd0;
      OP_LH, OP_LHU, OP_SH: s = 2'd1;
      default:              s = 2'd2;
    endcase
    return s;
  endfunction

  function automatic logic op_is_store(input logic [3:0] o);
    return (o == OP_SB) || (o == OP_SH) || (o == OP_SW) || (o == OP_SC);
  endfunction

  // Big-endian byte-lane enables: address 00 is the most significant lane.
  function automatic logic [3:0] lane_sel(input logic [3:0] o, input logic [1:0] a);
    logic [3:0] s;
    case (op_size(o))
      2'd0:    s = 4'b1000 >> a;
      2'd1:    s = a[1] ? 4'b0011 : 4'b1100;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Narrow stores replicate the datum across every lane it could occupy.
  function automatic logic [31:0] store_data(input logic [3:0] o, input logic [31:0] w);
    logic [31:0] d;
    case (op_size(o))
      2'd0:    d = {4{w[7:0]}};
      2'd1:    d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  // Extract the addressed lane and sign/zero extend it.
  function automatic logic [31:0] load_data(input logic [3:0] o, input logic [1:0] a,
                                            input logic [31:0] rd);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] r;
    case (a)
      2'b00:   b = rd[31:24];
      2'b01:   b = rd[23:16];
      2'b10:   b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = a[1] ? rd[15:0] : rd[31:16];
    case (o)
      OP_LB:   r = $signed({{24{b[7]}}, b});
      OP_LBU:  r = $signed({24'd0, b});
      OP_LH:   r = $signed({{16{h[15]}}, h});
      OP_LHU:  r = $signed({16'd0, h});
      default: r = $signed(rd);
    endcase
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic [31:0]       wd_q, wd_d;
  logic              flush_q, flush_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        exc_q, exc_d;
  logic [ADDR_W-1:0] bad_q, bad_d;
  logic              llbit_q;
  logic [ADDR_W-3:0] link_q;

  logic op_valid;
  logic accept;
  logic misalign;
  logic sc_fail;
  logic flushed;
  logic timeout;
  logic resp_done;

  assign op_valid  = (op <= OP_SC);
  assign accept    = (state_q == S_IDLE) && req_valid && op_valid && !flush;
  assign misalign  = ((op_size(op) == 2'd1) && addr[0]) ||
                     ((op_size(op) == 2'd2) && (addr[1:0] != 2'b00));
  assign sc_fail   = (op == OP_SC) && (!llbit_q || (addr[ADDR_W-1:2] != link_q));
  assign flushed   = flush_q || flush;
  assign timeout   = (cnt_q == CNT_LAST);
  assign resp_done = (state_q == S_RESP) && !flush;

  assign stall_req  = accept || (state_q == S_BUS);
  assign done       = resp_done;
  assign rdata_o    = rdata_q;
  assign exc_o      = exc_q;
  assign bad_addr_o = bad_q;
  assign llbit_o    = llbit_q;
  assign bus_req    = (state_q == S_BUS);
  assign bus_we     = (state_q == S_BUS) && we_q;
  assign bus_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_sel    = sel_q;
  assign bus_wdata  = wd_q;

  // Next-state logic: accept/check in IDLE, bus handshake in BUS, one-cycle RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    wd_d    = wd_q;
    flush_d = flush_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    bad_d   = bad_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op;
          addr_d  = addr;
          sel_d   = lane_sel(op, addr[1:0]);
          we_d    = op_is_store(op);
          wd_d    = store_data(op, wdata_in);
          flush_d = 1'b0;
          cnt_d   = '0;
          if (misalign) begin
            // Address error short-circuits the bus entirely.
            state_d = S_RESP;
            exc_d   = op_is_store(op) ? EXC_ADES : EXC_ADEL;
            bad_d   = addr;
            rdata_d = 32'd0;
          end else if (sc_fail) begin
            // Failed SC reports 0 without touching memory.
            state_d = S_RESP;
            exc_d   = EXC_NONE;
            bad_d   = '0;
            rdata_d = 32'd0;
          end else begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // A flush mid-transfer lets the bus cycle finish but drops the result.
        flush_d = flushed;
        if (bus_err || (timeout && !bus_ack)) begin
          state_d = flushed ? S_IDLE : S_RESP;
          if (!flushed) begin
            exc_d   = EXC_BUS;
            bad_d   = addr_q;
            rdata_d = 32'd0;
          end
        end else if (bus_ack) begin
          state_d = flushed ? S_IDLE : S_RESP;
          if (!flushed) begin
            exc_d = EXC_NONE;
            bad_d = '0;
            if (op_q == OP_SC) begin
              rdata_d = 32'd1;
            end else if (op_is_store(op_q)) begin
              rdata_d = 32'd0;
            end else begin
              rdata_d = load_data(op_q, addr_q[1:0], bus_rdata);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched request and held result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 4'd0;
      addr_q  <= '0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      wd_q    <= 32'd0;
      flush_q <= 1'b0;
      rdata_q <= 32'd0;
      exc_q   <= EXC_NONE;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      flush_q <= flush_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
      bad_q   <= bad_d;
    end
  end

  // Link bit: set by a clean LL, cleared by SC, stores to the link word,
  // exceptions or an explicit clear (which beats a simultaneous LL set).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llbit_q <= 1'b0;
      link_q  <= '0;
    end else if (llbit_clr) begin
      llbit_q <= 1'b0;
    end else if (resp_done) begin
      if ((exc_q != EXC_NONE) || (op_q == OP_SC)) begin
        llbit_q <= 1'b0;
      end else if (op_q == OP_LL) begin
        llbit_q <= 1'b1;
        link_q  <= addr_q[ADDR_W-1:2];
      end else if (op_is_store(op_q) && (addr_q[ADDR_W-1:2] == link_q)) begin
        llbit_q <= 1'b0;
      end
    end
  end

endmodule
